// File: rtl/cp0_exc_sequencer.sv
// Owns CP0's single write port: arbitrates mtc0/exception/interrupt/eret at commit and
// expands exception entry and eret into ordered CP0 writes, then a one-cycle flush+redirect.
module cp0_exc_sequencer #(
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic              exc_valid,
  input  logic [4:0]        exc_code,
  input  logic [DATA_W-1:0] exc_pc,
  input  logic [DATA_W-1:0] exc_badvaddr,
  input  logic              exc_delay_slot,
  input  logic              eret_valid,
  input  logic              mtc0_en,
  input  logic [ADDR_W-1:0] mtc0_addr,
  input  logic [DATA_W-1:0] mtc0_data,
  input  logic [DATA_W-1:0] status_in,
  input  logic [DATA_W-1:0] cause_in,
  input  logic [DATA_W-1:0] epc_in,
  output logic              cp0_write_en,
  output logic [ADDR_W-1:0] cp0_write_addr,
  output logic [DATA_W-1:0] cp0_write_data,
  output logic              stall,
  output logic              flush,
  output logic [DATA_W-1:0] redirect_pc
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_EPC    = 3'd1;
  localparam logic [2:0] S_W_BADV   = 3'd2;
  localparam logic [2:0] S_W_CAUSE  = 3'd3;
  localparam logic [2:0] S_W_STATUS = 3'd4;
  localparam logic [2:0] S_REDIR    = 3'd5;

  logic [2:0]        state;
  logic [4:0]        code_q;
  logic              bd_q;
  logic              eret_q;
  logic [DATA_W-1:0] epc_q;
  logic [DATA_W-1:0] badv_q;
  logic [DATA_W-1:0] eret_epc_q;

  logic       int_pending;
  logic       take_exc;
  logic [4:0] acc_code;
  logic       acc_badv;
  logic       code_badv;

  always_comb begin
    int_pending = inst_valid & status_in[0] & ~status_in[1] &
                  (|(cause_in[15:10] & status_in[15:10]));
    take_exc    = exc_valid | int_pending;
    acc_code    = exc_valid ? exc_code : 5'd0;
    acc_badv    = (acc_code == 5'd4) || (acc_code == 5'd5);
    code_badv   = (code_q == 5'd4) || (code_q == 5'd5);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      code_q     <= '0;
      bd_q       <= 1'b0;
      eret_q     <= 1'b0;
      epc_q      <= '0;
      badv_q     <= '0;
      eret_epc_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (take_exc || eret_valid) begin
            code_q     <= acc_code;
            bd_q       <= exc_delay_slot;
            epc_q      <= exc_delay_slot ? (exc_pc - DATA_W'(4)) : exc_pc;
            badv_q     <= exc_badvaddr;
            eret_epc_q <= epc_in;
            eret_q     <= ~take_exc;
          end
          // Nested exceptions (EXL already set) must not overwrite EPC.
          if (take_exc) begin
            if (!status_in[1]) state <= S_W_EPC;
            else               state <= acc_badv ? S_W_BADV : S_W_CAUSE;
          end else if (eret_valid) begin
            state <= S_W_STATUS;
          end
        end
        S_W_EPC:    state <= code_badv ? S_W_BADV : S_W_CAUSE;
        S_W_BADV:   state <= S_W_CAUSE;
        S_W_CAUSE:  state <= S_W_STATUS;
        S_W_STATUS: state <= S_REDIR;
        default:    state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    cp0_write_en   = 1'b0;
    cp0_write_addr = '0;
    cp0_write_data = '0;
    flush          = 1'b0;
    redirect_pc    = '0;
    stall          = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (mtc0_en && !take_exc && !eret_valid) begin
          cp0_write_en   = 1'b1;
          cp0_write_addr = mtc0_addr;
          cp0_write_data = mtc0_data;
        end
      end
      S_W_EPC: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_W'(14);
        cp0_write_data = epc_q;
      end
      S_W_BADV: begin
        cp0_write_en   = 1'b1;
        cp0_write_addr = ADDR_W'(8);
        cp0_write_data = badv_q;
      end
      S_W_CAUSE: begin
        cp0_write_en        = 1'b1;
        cp0_write_addr      = ADDR_W'(13);
        cp0_write_data      = cause_in;
        cp0_write_data[31]  = bd_q;
        cp0_write_data[6:2] = code_q;
      end
      S_W_STATUS: begin
        cp0_write_en      = 1'b1;
        cp0_write_addr    = ADDR_W'(12);
        cp0_write_data    = status_in;
        cp0_write_data[1] = ~eret_q;
      end
      S_REDIR: begin
        flush       = 1'b1;
        redirect_pc = eret_q ? eret_epc_q : EXC_VECTOR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Randomized + directed bench for cp0_exc_sequencer: a transaction-level model pushes
// expected per-cycle CP0 activity into a queue, an independent monitor pops and compares.
module tb_cp0_exc_sequencer;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid, exc_valid, exc_delay_slot, eret_valid, mtc0_en;
  logic [4:0]  exc_code, mtc0_addr;
  logic [31:0] exc_pc, exc_badvaddr, mtc0_data, status_in, cause_in, epc_in;
  logic        cp0_write_en, stall, flush;
  logic [4:0]  cp0_write_addr;
  logic [31:0] cp0_write_data, redirect_pc;

  cp0_exc_sequencer dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .exc_valid(exc_valid),
    .exc_code(exc_code), .exc_pc(exc_pc), .exc_badvaddr(exc_badvaddr),
    .exc_delay_slot(exc_delay_slot), .eret_valid(eret_valid), .mtc0_en(mtc0_en),
    .mtc0_addr(mtc0_addr), .mtc0_data(mtc0_data), .status_in(status_in),
    .cause_in(cause_in), .epc_in(epc_in), .cp0_write_en(cp0_write_en),
    .cp0_write_addr(cp0_write_addr), .cp0_write_data(cp0_write_data),
    .stall(stall), .flush(flush), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc; bit we; logic [4:0] addr; logic [31:0] data; bit stall; bit flush; logic [31:0] pc;
  } exp_t;

  typedef struct {
    bit iv; bit exc; logic [4:0] code; logic [31:0] pc; logic [31:0] bad; bit bd;
    bit eret; bit mtc0; logic [4:0] maddr; logic [31:0] mdata;
    logic [31:0] status; logic [31:0] cause; logic [31:0] epc;
  } txn_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input int c, input bit we, input logic [4:0] a, input logic [31:0] d,
                      input bit st, input bit fl, input logic [31:0] pc);
    exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.data = d; e.stall = st; e.flush = fl; e.pc = pc;
    q.push_back(e);
  endtask

  // Transaction-level reference: what CP0 should see for a commit issued in cycle T.
  task automatic model(input txn_t t, input int T, output int n);
    bit          intp;
    logic [4:0]  c;
    logic [31:0] d;
    int          k;
    intp = t.iv && t.status[0] && !t.status[1] && ((t.cause[15:10] & t.status[15:10]) != 6'd0);
    n = 0;
    if (t.exc || intp) begin
      c = t.exc ? t.code : 5'd0;
      k = 1;
      if (!t.status[1]) begin
        push(T + k, 1, 5'd14, t.bd ? t.pc - 32'd4 : t.pc, 1, 0, 0); k++;
      end
      if (c == 5'd4 || c == 5'd5) begin
        push(T + k, 1, 5'd8, t.bad, 1, 0, 0); k++;
      end
      d = t.cause; d[31] = t.bd; d[6:2] = c;
      push(T + k, 1, 5'd13, d, 1, 0, 0); k++;
      push(T + k, 1, 5'd12, t.status | 32'h2, 1, 0, 0); k++;
      push(T + k, 0, 5'd0, 32'd0, 1, 1, VEC);
      n = k;
    end else if (t.eret) begin
      push(T + 1, 1, 5'd12, t.status & ~32'h2, 1, 0, 0);
      push(T + 2, 0, 5'd0, 32'd0, 1, 1, t.epc);
      n = 2;
    end else if (t.mtc0) begin
      push(T, 1, t.maddr, t.mdata, 0, 0, 0);
    end
  endtask

  exp_t me;
  bit   mbad;
  always @(negedge clk) begin
    if (mon_en && (cp0_write_en || flush || stall)) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output cyc=%0d actual we=%b addr=%0d data=%h stall=%b flush=%b required idle",
                 cyc, cp0_write_en, cp0_write_addr, cp0_write_data, stall, flush);
      end else begin
        me = q.pop_front();
        mbad = (me.cyc != cyc) || (cp0_write_en !== me.we) || (stall !== me.stall) ||
               (flush !== me.flush) ||
               (me.we && ((cp0_write_addr !== me.addr) || (cp0_write_data !== me.data))) ||
               (me.flush && (redirect_pc !== me.pc));
        if (mbad) begin
          errors++;
          $display("FAIL cp0_seq actual cyc=%0d we=%b addr=%0d data=%h stall=%b flush=%b pc=%h required cyc=%0d we=%b addr=%0d data=%h stall=%b flush=%b pc=%h",
                   cyc, cp0_write_en, cp0_write_addr, cp0_write_data, stall, flush, redirect_pc,
                   me.cyc, me.we, me.addr, me.data, me.stall, me.flush, me.pc);
        end
      end
    end
  end

  task automatic idle();
    inst_valid = 0; exc_valid = 0; exc_code = 0; exc_pc = 0; exc_badvaddr = 0;
    exc_delay_slot = 0; eret_valid = 0; mtc0_en = 0; mtc0_addr = 0; mtc0_data = 0;
  endtask

  // While busy the pipeline is stalled; random commit-side noise must be ignored.
  task automatic junk();
    inst_valid = 1'($urandom); exc_valid = 1'($urandom); exc_code = 5'($urandom);
    exc_pc = $urandom; exc_badvaddr = $urandom; exc_delay_slot = 1'($urandom);
    eret_valid = 1'($urandom); mtc0_en = 1'($urandom);
    mtc0_addr = 5'($urandom); mtc0_data = $urandom;
  endtask

  task automatic drive(input txn_t t);
    inst_valid = t.iv; exc_valid = t.exc; exc_code = t.code; exc_pc = t.pc;
    exc_badvaddr = t.bad; exc_delay_slot = t.bd; eret_valid = t.eret;
    mtc0_en = t.mtc0; mtc0_addr = t.maddr; mtc0_data = t.mdata;
    status_in = t.status; cause_in = t.cause; epc_in = t.epc;
  endtask

  task automatic run_txn(input txn_t t, input bit noisy);
    int n;
    drive(t);
    model(t, cyc, n);
    repeat (n) begin
      @(posedge clk); #1;
      if (noisy) junk(); else idle();
    end
    @(posedge clk); #1;
    idle();
  endtask

  function automatic txn_t blank();
    txn_t t;
    t.iv = 1; t.exc = 0; t.code = 0; t.pc = 0; t.bad = 0; t.bd = 0; t.eret = 0;
    t.mtc0 = 0; t.maddr = 0; t.mdata = 0; t.status = 0; t.cause = 0; t.epc = 0;
    return t;
  endfunction

  txn_t t;
  int   T0;
  logic [4:0] codes [6] = '{5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

  initial begin
    rst = 1; idle(); status_in = 0; cause_in = 0; epc_in = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_we", {31'd0, cp0_write_en}, 32'd0);
    chk("reset_addr", {27'd0, cp0_write_addr}, 32'd0);
    chk("reset_data", cp0_write_data, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_flush", {31'd0, flush}, 32'd0);
    chk("reset_redirect", redirect_pc, 32'd0);
    mon_en = 1;
    @(posedge clk); #1;

    t = blank(); t.exc = 1; t.code = 5'd8; t.pc = 32'h80001000; t.status = 32'h0000FF01;
    run_txn(t, 0);
    t = blank(); t.exc = 1; t.code = 5'd4; t.pc = 32'h80002004; t.bd = 1; t.bad = 32'h3;
    t.status = 32'h0000FF01;
    run_txn(t, 1);
    t = blank(); t.exc = 1; t.code = 5'd12; t.pc = 32'h80002100; t.status = 32'h0000FF03;
    run_txn(t, 1);
    t = blank(); t.eret = 1; t.epc = 32'h80003000; t.status = 32'h0000FF03;
    run_txn(t, 1);
    t = blank(); t.mtc0 = 1; t.maddr = 5'd11; t.mdata = 32'h55;
    run_txn(t, 0);
    t = blank(); t.mtc0 = 1; t.maddr = 5'd11; t.mdata = 32'h77; t.exc = 1; t.code = 5'd10;
    t.pc = 32'h80000200; t.status = 32'h0000FF01;
    run_txn(t, 0);

    for (int i = 0; i < 300; i++) begin
      t.iv = 1'($urandom); t.exc = ($urandom_range(0, 3) == 0);
      t.code = codes[$urandom_range(0, 5)];
      t.pc = $urandom & 32'hFFFF_FFFC; t.bad = $urandom; t.bd = 1'($urandom);
      t.eret = ($urandom_range(0, 3) == 0); t.mtc0 = 1'($urandom);
      t.maddr = 5'($urandom); t.mdata = $urandom;
      t.status = $urandom; t.cause = $urandom; t.epc = $urandom;
      run_txn(t, 1'($urandom));
    end

    // Interrupt entry interrupted by reset after the Cause write.
    t = blank(); t.pc = 32'h80004000; t.cause = 32'h00000400; t.status = 32'h00000401;
    drive(t);
    T0 = cyc;
    begin
      int n;
      model(t, T0, n);
    end
    @(posedge clk); #1; idle();
    @(posedge clk); #1;
    rst = 1;
    while (q.size() > 0 && q[$].cyc > T0 + 2) void'(q.pop_back());
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_stall", {31'd0, stall}, 32'd0);
    chk("rst_mid_flush", {31'd0, flush}, 32'd0);
    chk("rst_mid_we", {31'd0, cp0_write_en}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
